// File: rtl/stack_host_pkg.sv
// Shared types for the stack host controller: FSM states, op and error codes.
package stack_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_FULL    = 2'b01,
        ERR_EMPTY   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;

    // Only a push in flight may drive the shared bus.
    function automatic logic drives_bus(state_t s, logic op);
        return (op == OP_PUSH) &&
               (s == S_ISSUE || s == S_WAIT_BUSY || s == S_WAIT_DONE);
    endfunction

endpackage

// File: rtl/stack_host_ctrl_if.sv
// Host-side request/response handshake of the stack controller.
interface stack_host_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_host_timer.sv
// Clearable wait-cycle counter; tc flags the last permitted wait cycle.
module stack_host_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != W'(TIMEOUT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High during the TIMEOUT-th wait cycle; the count reaches TIMEOUT on its edge.
    assign tc = en && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/stack_host_ctrl.sv
// Initiator for the 8-bit push/pop stack pin protocol with a shadow fill level.
module stack_host_ctrl
    import stack_host_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    stack_host_ctrl_if.slave  host,
    output logic [LVL_W-1:0]  level,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_dout,
    output logic [DATA_W-1:0] stk_doe,
    input  logic [DATA_W-1:0] stk_din,
    input  logic              stk_done,
    input  logic              stk_empty,
    input  logic              stk_full
);
    state_t            state_q, state_d;
    logic              op_q, op_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [LVL_W-1:0]  level_q, level_d;
    err_t              err_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic              drive_d;

    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_err_q;
    logic              push_q, pop_q;
    logic [DATA_W-1:0] dout_q, doe_q;

    stack_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = ERR_OK;
        rd_data_d = '0;
        level_d   = level_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        // Request fields are latched in the accept cycle.
        op_n      = (state_q == S_IDLE) ? host.req_op   : op_q;
        data_n    = (state_q == S_IDLE) ? host.req_data : data_q;

        unique case (state_q)
            S_IDLE: begin
                if (host.req_valid) begin
                    if (host.req_op == OP_PUSH && stk_full) begin
                        state_d = S_RESP;
                        err_d   = ERR_FULL;
                    end else if (host.req_op == OP_POP && stk_empty) begin
                        state_d = S_RESP;
                        err_d   = ERR_EMPTY;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmr_clr = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = S_RESP;
                    err_d   = ERR_TIMEOUT;
                end else if (!stk_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                tmr_en = 1'b1;
                if (stk_done) begin
                    state_d = S_RESP;
                    if (op_q == OP_POP) begin
                        rd_data_d = stk_din;
                        if (level_q != '0) level_d = level_q - 1'b1;
                    end else begin
                        if (level_q != LVL_W'(DEPTH)) level_d = level_q + 1'b1;
                    end
                end else if (tmr_tc) begin
                    state_d = S_RESP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drive_d = drives_bus(state_d, op_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            dout_q      <= '0;
            doe_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_n;
            data_q      <= data_n;
            level_q     <= level_d;
            ready_q     <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            rsp_data_q  <= rd_data_d;
            rsp_err_q   <= err_d;
            push_q      <= (state_d == S_ISSUE) && (op_n == OP_PUSH);
            pop_q       <= (state_d == S_ISSUE) && (op_n == OP_POP);
            dout_q      <= drive_d ? data_n : '0;
            doe_q       <= drive_d ? '1 : '0;
        end
    end

    assign host.req_ready = ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;
    assign level          = level_q;
    assign stk_push       = push_q;
    assign stk_pop        = pop_q;
    assign stk_dout       = dout_q;
    assign stk_doe        = doe_q;
endmodule

// File: tb/tb_stack_host_ctrl.sv
// Directed bench: behavioural stack model plus table of host transactions.
module tb_stack_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] level;
    logic       stk_push, stk_pop;
    logic [7:0] stk_dout, stk_doe, stk_din;
    logic       stk_done, stk_empty, stk_full;

    stack_host_ctrl_if #(.DATA_W(8)) hif ();

    stack_host_ctrl #(.DATA_W(8), .DEPTH(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hif),
        .level     (level),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_dout  (stk_dout),
        .stk_doe   (stk_doe),
        .stk_din   (stk_din),
        .stk_done  (stk_done),
        .stk_empty (stk_empty),
        .stk_full  (stk_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];
    int         sp;
    int         busy;
    int         m_dly;
    bit         m_stuck;

    typedef struct {
        logic       op;
        logic [7:0] data;
        int         dly;
        logic [1:0] exp_err;
        logic [7:0] exp_data;
        int         exp_level;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sp        = 0;
        busy      = 0;
        stk_done  = 1'b1;
        stk_din   = 8'h00;
        stk_empty = 1'b1;
        stk_full  = 1'b0;
    endtask

    // Stack reacts to strobes seen after each edge; done stays low m_dly cycles.
    task automatic step();
        @(posedge clk);
        #1;
        if (stk_push && !m_stuck) begin
            mem[sp]  = stk_dout;
            sp++;
            busy     = m_dly;
            stk_done = 1'b0;
        end else if (stk_pop && !m_stuck) begin
            sp--;
            stk_din  = mem[sp];
            busy     = m_dly;
            stk_done = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) stk_done = 1'b1;
        end
        stk_empty = (sp == 0);
        stk_full  = (sp == 16);
    endtask

    task automatic do_txn(
        input  logic       op,
        input  logic [7:0] d,
        input  int         dly,
        input  bit         stuck,
        output logic [7:0] rd,
        output logic [1:0] re,
        output int         lvl,
        output int         lat,
        output int         n_push,
        output int         n_pop,
        output bit         bus_ok
    );
        int k;
        bit got;
        m_dly   = (dly < 2) ? 2 : dly;
        m_stuck = stuck;
        k = 0;
        while (!hif.req_ready && k < 20) begin
            step();
            k++;
        end
        chk("ready_wait", {31'b0, hif.req_ready}, 32'd1);
        hif.req_valid = 1'b1;
        hif.req_op    = op;
        hif.req_data  = d;
        step();
        hif.req_valid = 1'b0;
        lat = 2; got = 0; n_push = 0; n_pop = 0; bus_ok = 1;
        rd = 8'h00; re = 2'b00; lvl = -1;
        for (int i = 0; i < 40; i++) begin
            if (stk_push) n_push++;
            if (stk_pop)  n_pop++;
            if (hif.rsp_valid) begin
                if (stk_doe !== 8'h00) bus_ok = 0;
                got = 1;
                rd  = hif.rsp_data;
                re  = hif.rsp_err;
                lvl = int'(level);
                break;
            end
            if (op == 1'b1) begin
                if (stk_doe !== 8'h00) bus_ok = 0;
            end else begin
                if (stk_doe !== 8'hFF || stk_dout !== d) bus_ok = 0;
            end
            step();
            lat++;
        end
        chk("rsp_seen", {31'b0, got}, 32'd1);
        if (got) step();
    endtask

    logic [7:0] rd;
    logic [1:0] re;
    int         lvl, lat, np, npo;
    bit         bok;

    initial begin
        tbl[0] = '{1'b0, 8'hA5, 2, 2'b00, 8'h00, 1};
        tbl[1] = '{1'b1, 8'h00, 3, 2'b00, 8'hA5, 0};
        tbl[2] = '{1'b1, 8'h00, 2, 2'b10, 8'h00, 0};
        tbl[3] = '{1'b0, 8'h3C, 2, 2'b00, 8'h00, 1};
        tbl[4] = '{1'b0, 8'h7E, 3, 2'b00, 8'h00, 2};
        tbl[5] = '{1'b1, 8'h00, 4, 2'b00, 8'h7E, 1};
        tbl[6] = '{1'b1, 8'h00, 2, 2'b00, 8'h3C, 0};

        hif.req_valid = 1'b0;
        hif.req_op    = 1'b0;
        hif.req_data  = 8'h00;
        m_dly = 2; m_stuck = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, hif.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, hif.rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'b0, hif.rsp_data}, 32'd0);
        chk("rst_rsp_err", {30'b0, hif.rsp_err}, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_strobes", {30'b0, stk_push, stk_pop}, 32'd0);
        chk("rst_bus", {16'b0, stk_doe, stk_dout}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            bit rej;
            rej = (tbl[i].exp_err != 2'b00);
            do_txn(tbl[i].op, tbl[i].data, tbl[i].dly, 1'b0, rd, re, lvl, lat, np, npo, bok);
            chk($sformatf("v%0d_err", i), {30'b0, re}, {30'b0, tbl[i].exp_err});
            chk($sformatf("v%0d_data", i), {24'b0, rd}, {24'b0, tbl[i].exp_data});
            chk($sformatf("v%0d_level", i), lvl, tbl[i].exp_level);
            chk($sformatf("v%0d_lat", i), lat, rej ? 2 : 3 + tbl[i].dly);
            chk($sformatf("v%0d_push", i), np, (!rej && tbl[i].op == 1'b0) ? 1 : 0);
            chk($sformatf("v%0d_pop", i), npo, (!rej && tbl[i].op == 1'b1) ? 1 : 0);
            chk($sformatf("v%0d_bus", i), {31'b0, bok}, 32'd1);
        end

        // Stack never drops done: abort after 15 wait cycles.
        do_txn(1'b0, 8'h55, 2, 1'b1, rd, re, lvl, lat, np, npo, bok);
        chk("to_err", {30'b0, re}, 32'd3);
        chk("to_data", {24'b0, rd}, 32'd0);
        chk("to_level", lvl, 0);
        chk("to_lat", lat, 18);
        chk("to_bus", {31'b0, bok}, 32'd1);
        chk("to_push", np, 1);

        for (int i = 0; i < 16; i++) begin
            do_txn(1'b0, 8'(i * 7 + 1), 2, 1'b0, rd, re, lvl, lat, np, npo, bok);
            if (i == 15) begin
                chk("fill_err", {30'b0, re}, 32'd0);
                chk("fill_level", lvl, 16);
            end
        end
        chk("model_full", {31'b0, stk_full}, 32'd1);
        do_txn(1'b0, 8'hEE, 2, 1'b0, rd, re, lvl, lat, np, npo, bok);
        chk("full_err", {30'b0, re}, 32'd1);
        chk("full_level", lvl, 16);
        chk("full_push", np, 0);
        chk("full_lat", lat, 2);
        chk("full_bus", {31'b0, bok}, 32'd1);

        // Reset mid-push while waiting on done.
        model_reset();
        m_dly = 6; m_stuck = 0;
        hif.req_valid = 1'b1;
        hif.req_op    = 1'b0;
        hif.req_data  = 8'h99;
        step();
        hif.req_valid = 1'b0;
        step();
        step();
        chk("mid_doe", {24'b0, stk_doe}, 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_doe", {24'b0, stk_doe}, 32'd0);
        chk("ar_strobes", {30'b0, stk_push, stk_pop}, 32'd0);
        chk("ar_rsp_valid", {31'b0, hif.rsp_valid}, 32'd0);
        chk("ar_level", {27'b0, level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        np = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (hif.rsp_valid || stk_push || stk_pop) np++;
        end
        chk("ar_quiet", np, 0);
        chk("ar_ready", {31'b0, hif.req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
